// File: rtl/multibit_mcp_rx_arb.sv
// ---------------------------------------------------------------------------
// multibit_mcp_rx_arb
//
// Receive side of a multi-channel multi-cycle-path (MCP) toggle synchroniser.
// Everything here runs in the destination clock domain.
//
// Each of NUM_CH foreign-domain channels presents a request toggle plus a
// payload. The payload is held stable until the matching ack toggle comes
// back. For each channel:
//   - the request toggle is synchronised through SYNC_STAGES flops;
//   - the toggle is turned into a single-cycle pulse;
//   - the payload is captured into a one-entry slot.
// Full slots are merged into one valid/ready stream by a round-robin
// arbiter. A channel's ack toggle flips when its slot is released into the
// output register.
//
// Parameters
//   NUM_CH       number of source channels (>= 1)
//   DATA_WIDTH   payload width per channel
//   SYNC_STAGES  flops per synchroniser chain (>= 2)
//
// Ports
//   clk       destination clock; all state changes on its rising edge
//   reset_n   asynchronous active-low reset
//   req_tgl   per-channel request toggles (asynchronous)
//   req_data  per-channel payloads; channel i is [i*DATA_WIDTH +: DATA_WIDTH]
//   ack_tgl   per-channel ack toggles returned to the sources
//   m_valid   output stream valid
//   m_data    output stream payload
//   m_ch      source channel of m_data
//   m_ready   output stream ready
//   overrun   sticky per-channel protocol-violation flags
//
// Optional feature
//   Define MULTIBIT_MCP_RX_OVERRUN_DET_EN to enable overrun detection.
//   With it enabled, a request that arrives while its slot is still full
//   sets overrun[i] until reset. Without it, overrun is tied to zero.
// ---------------------------------------------------------------------------
module multibit_mcp_rx_arb #(
  parameter int NUM_CH      = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int SYNC_STAGES = 2,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_CH-1:0]            req_tgl,
  input  logic [NUM_CH*DATA_WIDTH-1:0] req_data,
  output logic [NUM_CH-1:0]            ack_tgl,
  output logic                         m_valid,
  output logic [DATA_WIDTH-1:0]        m_data,
  output logic [CH_W-1:0]              m_ch,
  input  logic                         m_ready,
  output logic [NUM_CH-1:0]            overrun
);

  // Synchroniser chains: one vector per stage, bit i belongs to channel i.
  logic [NUM_CH-1:0]     sync_q [SYNC_STAGES];
  logic [NUM_CH-1:0]     sync_d [SYNC_STAGES];
  logic [NUM_CH-1:0]     edge_q;
  logic [NUM_CH-1:0]     edge_d;
  logic [NUM_CH-1:0]     pulse_s;

  // One-entry slots.
  logic [NUM_CH-1:0]     full_q;
  logic [NUM_CH-1:0]     full_d;
  logic [DATA_WIDTH-1:0] slot_data_q [NUM_CH];
  logic [DATA_WIDTH-1:0] slot_data_d [NUM_CH];

  // Arbiter and output register.
  logic [CH_W-1:0]       rr_ptr_q;
  logic [CH_W-1:0]       rr_ptr_d;
  logic                  any_full_s;
  logic [CH_W-1:0]       gnt_s;
  logic [DATA_WIDTH-1:0] gnt_data_s;
  logic                  take_s;
  logic                  load_s;
  logic [NUM_CH-1:0]     ack_q;
  logic [NUM_CH-1:0]     ack_d;
  logic                  m_valid_q;
  logic                  m_valid_d;
  logic [DATA_WIDTH-1:0] m_data_q;
  logic [DATA_WIDTH-1:0] m_data_d;
  logic [CH_W-1:0]       m_ch_q;
  logic [CH_W-1:0]       m_ch_d;

  // Synchroniser shift and edge-register next-state.
  always_comb begin
    sync_d[0] = req_tgl;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
    edge_d  = sync_q[SYNC_STAGES-1];
    pulse_s = sync_q[SYNC_STAGES-1] ^ edge_q;
  end

  // Round-robin search.
  // The first pass looks for the lowest full slot at or above rr_ptr. The
  // second pass looks for the lowest full slot overall, which is the
  // wrapped choice. Loop indices are constants after unrolling, so there is
  // no variable indexing into the slot arrays.
  always_comb begin
    logic            found_hi;
    logic            found_lo;
    logic [CH_W-1:0] gnt_hi;
    logic [CH_W-1:0] gnt_lo;
    found_hi = 1'b0;
    found_lo = 1'b0;
    gnt_hi   = '0;
    gnt_lo   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (full_q[i] && !found_hi && (i >= int'(rr_ptr_q))) begin
        found_hi = 1'b1;
        gnt_hi   = CH_W'(i);
      end else begin
        found_hi = found_hi;
      end
      if (full_q[i] && !found_lo) begin
        found_lo = 1'b1;
        gnt_lo   = CH_W'(i);
      end else begin
        found_lo = found_lo;
      end
    end
    any_full_s = found_lo;
    if (found_hi) begin
      gnt_s = gnt_hi;
    end else begin
      gnt_s = gnt_lo;
    end
    gnt_data_s = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt_s == CH_W'(i)) begin
        gnt_data_s = slot_data_q[i];
      end else begin
        gnt_data_s = gnt_data_s;
      end
    end
  end

  // The output register may accept a new word when it is empty or its
  // current word is being consumed this cycle.
  assign take_s = !m_valid_q || m_ready;
  assign load_s = take_s && any_full_s;

  // Slot, ack, arbiter-pointer and output-register next-state.
  always_comb begin
    full_d      = full_q;
    slot_data_d = slot_data_q;
    ack_d       = ack_q;
    rr_ptr_d    = rr_ptr_q;
    m_valid_d   = m_valid_q;
    m_data_d    = m_data_q;
    m_ch_d      = m_ch_q;

    if (load_s) begin
      m_valid_d = 1'b1;
      m_data_d  = gnt_data_s;
      m_ch_d    = gnt_s;
      if (gnt_s == CH_W'(NUM_CH - 1)) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = gnt_s + CH_W'(1);
      end
    end else if (take_s) begin
      m_valid_d = 1'b0;
    end else begin
      m_valid_d = m_valid_q;
    end

    for (int i = 0; i < NUM_CH; i++) begin
      // A granted slot is always full, so release and capture never collide.
      if (load_s && (gnt_s == CH_W'(i))) begin
        full_d[i] = 1'b0;
        ack_d[i]  = ~ack_q[i];
      end else begin
        full_d[i] = full_d[i];
      end
      // The test uses the current (pre-release) full bit. A request that
      // lands in the same cycle its slot is freed is therefore dropped.
      if (pulse_s[i] && !full_q[i]) begin
        full_d[i]      = 1'b1;
        slot_data_d[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        slot_data_d[i] = slot_data_d[i];
      end
    end
  end

  // State registers for synchronisers, slots, arbiter and output stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
      edge_q <= '0;
      full_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        slot_data_q[i] <= '0;
      end
      rr_ptr_q  <= '0;
      ack_q     <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_ch_q    <= '0;
    end else begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_d[s];
      end
      edge_q <= edge_d;
      full_q <= full_d;
      for (int i = 0; i < NUM_CH; i++) begin
        slot_data_q[i] <= slot_data_d[i];
      end
      rr_ptr_q  <= rr_ptr_d;
      ack_q     <= ack_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_ch_q    <= m_ch_d;
    end
  end

  assign ack_tgl = ack_q;
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_ch    = m_ch_q;

`ifdef MULTIBIT_MCP_RX_OVERRUN_DET_EN
  logic [NUM_CH-1:0] overrun_q;
  logic [NUM_CH-1:0] overrun_d;

  // Sticky flag: a request seen while its slot still holds a word.
  always_comb begin
    overrun_d = overrun_q | (pulse_s & full_q);
  end

  // Overrun flag register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overrun_q <= '0;
    end else begin
      overrun_q <= overrun_d;
    end
  end

  assign overrun = overrun_q;
`else
  assign overrun = '0;
`endif

endmodule
